bcd_countdown_mux: RTL and testbench

Parametrised BCD countdown timer with a multiplexed seven-segment driver, the next-generation phase timer for the traffic-light controller. It loads an N-digit BCD preset, decrements it once per tick derived from clk_50, and pulses done when it reaches zero. It also time-multiplexes the digits onto one shared segment bus. Pause and restart are supported, and digit count and tick rate are parameters.

---
 rtl/bcd_countdown_mux.sv | 140 ++++++++++++++
 tb/tb_bcd_countdown_mux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_mux.sv
// bcd_countdown_mux: BCD countdown phase timer with multiplexed seven-segment digit driver.
// Ports:
//   clk_50     - system clock, all logic on the rising edge
//   clr        - asynchronous active-low reset
//   start_i    - load load_val_i (digits above 9 clamp to 9) and run
//   load_val_i - BCD preset, digit 0 in [3:0]
//   pause_i    - freezes prescaler and count while running
//   value_o    - current BCD count
//   busy_o     - counting or paused
//   done_o     - one-cycle pulse when the count expires
//   seg_o      - active-low segments {g,f,e,d,c,b,a} of the enabled digit
//   dig_en_o   - one-hot active-high digit enable
module bcd_countdown_mux #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 2,
    parameter int MUX_DIV = 50000
) (
    input  logic                  clk_50,
    input  logic                  clr,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  pause_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     dig_en_o
);
    localparam int W   = 4 * DIGITS;
    localparam int PRE = CLK_HZ / TICK_HZ - 1;
    localparam int PW  = $clog2(PRE + 1);
    localparam int MW  = MUX_DIV > 1 ? $clog2(MUX_DIV) : 1;
    localparam int SW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_T  = PW'(PRE);
    localparam logic [MW-1:0] MUX_T  = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0] LAST_T = SW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      value_q, value_d, load_s, dec_v;
    logic [PW-1:0]     pre_q, pre_d;
    logic [MW-1:0]     mux_q, mux_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_en_q, dig_en_d;
    logic              borrow, active, run_en, tick, blank;
    logic [3:0]        digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Clamp the preset and build the borrow-chain decrement of the current count.
    always_comb begin
        borrow = 1'b1;
        load_s = '0;
        dec_v  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_s[4*k +: 4] = load_val_i[4*k +: 4] > 4'd9 ? 4'd9 : load_val_i[4*k +: 4];
            dec_v[4*k +: 4]  = !borrow ? value_q[4*k +: 4] :
                               value_q[4*k +: 4] == 4'd0 ? 4'd9 : value_q[4*k +: 4] - 4'd1;
            borrow           = borrow && value_q[4*k +: 4] == 4'd0;
        end
    end

    assign active = state_q != IDLE;
    assign run_en = active && !start_i && !pause_i;
    assign tick   = run_en && pre_q == PRE_T;

    always_ff @(posedge clk_50 or negedge clr) begin
        if (!clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // start wins over pause and tick; a zero preset expires immediately.
    always_comb begin
        state_d = start_i ? (load_s == '0 ? IDLE : RUN) :
                  !active ? state_q :
                  tick && dec_v == '0 ? IDLE :
                  pause_i ? PAUSED : RUN;
    end

    // Display digit and blanking are taken from the registered count so seg and dig_en stay paired.
    assign digit = 4'(value_q >> {sel_q, 2'b00});
    assign blank = sel_q != '0 && (value_q >> {sel_q, 2'b00}) == '0;

    always_comb begin
        value_d  = start_i ? load_s : tick ? dec_v : value_q;
        pre_d    = start_i || tick ? '0 : run_en ? pre_q + 1'b1 : pre_q;
        done_d   = start_i ? load_s == '0 : tick && dec_v == '0;
        busy_d   = state_d != IDLE;
        mux_d    = mux_q == MUX_T ? '0 : mux_q + 1'b1;
        sel_d    = mux_q != MUX_T ? sel_q : sel_q == LAST_T ? '0 : sel_q + 1'b1;
        dig_en_d = DIGITS'(1) << sel_q;
        seg_d    = state_q == IDLE || blank ? 7'h7F : seg7(digit);
    end

    always_ff @(posedge clk_50 or negedge clr) begin
        if (!clr) begin
            value_q  <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mux_q    <= '0;
            sel_q    <= '0;
            dig_en_q <= DIGITS'(1);
            seg_q    <= 7'h7F;
        end else begin
            value_q  <= value_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mux_q    <= mux_d;
            sel_q    <= sel_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
        end
    end

    assign value_o  = value_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign seg_o    = seg_q;
    assign dig_en_o = dig_en_q;
endmodule

// File: tb/tb_bcd_countdown_mux.sv
// tb_bcd_countdown_mux: directed bench for bcd_countdown_mux with PRE=9, two digits, MUX_DIV=2.
// Ports: none; drives clk_50, clr, start_i, load_val_i, pause_i and checks every DUT output.
module tb_bcd_countdown_mux;
    logic       clk_50 = 1'b0;
    logic       clr = 1'b1;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic [7:0] load_val_i = '0;
    logic [7:0] value_o;
    logic       busy_o, done_o;
    logic [6:0] seg_o;
    logic [1:0] dig_en_o;
    int         n_tests = 0;
    int         n_fail = 0;
    int         ecount = 0;

    bcd_countdown_mux #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MUX_DIV(2)) dut (
        .clk_50(clk_50), .clr(clr), .start_i(start_i), .load_val_i(load_val_i),
        .pause_i(pause_i), .value_o(value_o), .busy_o(busy_o), .done_o(done_o),
        .seg_o(seg_o), .dig_en_o(dig_en_o)
    );

    always #5 clk_50 = ~clk_50;

    // Rising edges seen since reset was released; drives the expected digit scan.
    always @(posedge clk_50 or negedge clr) begin
        if (!clr) ecount <= 0;
        else      ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_start(input logic [7:0] v);
        start_i = 1'b1;
        load_val_i = v;
        step();
        start_i = 1'b0;
    endtask

    function automatic logic [7:0] bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int sel_of(input int e);
        return e == 0 ? 0 : ((e - 1) / 2) % 2;
    endfunction

    function automatic logic [1:0] exp_en(input int e);
        return sel_of(e) == 1 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [7:0] v, input int e);
        if (sel_of(e) == 0) return seg7(v[3:0]);
        return v[7:4] == 4'd0 ? 7'h7F : seg7(v[7:4]);
    endfunction

    // Follows a countdown of preset p (decimal) for n cycles after its start edge.
    task automatic run_count(input int p, input int n);
        logic [7:0] v;
        chk("load_value", value_o, bcd(p));
        chk("load_busy", busy_o, 1);
        for (int i = 1; i <= n; i++) begin
            step();
            v = bcd(i >= p * 10 ? 0 : p - i / 10);
            chk("value", value_o, v);
            chk("done", done_o, i == p * 10);
            chk("busy", busy_o, i < p * 10);
            chk("dig_en", dig_en_o, exp_en(ecount));
            if (i > p * 10) chk("seg_idle", seg_o, 7'h7F);
            else if (i % 10 != 0) chk("seg", seg_o, exp_seg(v, ecount));
        end
    endtask

    initial begin
        #2 clr = 1'b0;
        #10;
        chk("rst_value", value_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_dig_en", dig_en_o, 2'b01);
        chk("rst_seg", seg_o, 7'h7F);
        clr = 1'b1;
        step();

        do_start(8'h05);
        run_count(5, 55);

        do_start(8'h20);
        run_count(20, 205);

        do_start(8'h03);
        for (int i = 1; i <= 60; i++) begin
            step();
            chk("pause_value", value_o, bcd(i < 35 ? 3 : i < 45 ? 2 : i < 55 ? 1 : 0));
            chk("pause_done", done_o, i == 55);
            chk("pause_busy", busy_o, i < 55);
            if (i == 5) pause_i = 1'b1;
            if (i == 30) pause_i = 1'b0;
        end

        do_start(8'h07);
        run_count(7, 13);
        do_start(8'h29);
        run_count(29, 12);
        pause_i = 1'b1;
        do_start(8'h15);
        pause_i = 1'b0;
        run_count(15, 12);

        do_start(8'hAB);
        chk("clamp_value", value_o, 8'h99);
        chk("clamp_busy", busy_o, 1);
        step();
        step();
        #2 clr = 1'b0;
        #1;
        chk("clr_value", value_o, 0);
        chk("clr_dig_en", dig_en_o, 2'b01);
        chk("clr_seg", seg_o, 7'h7F);
        chk("clr_busy", busy_o, 0);
        chk("clr_done", done_o, 0);
        step();
        chk("clr_hold_done", done_o, 0);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_clr_done", done_o, 0);
            chk("post_clr_value", value_o, 0);
        end

        do_start(8'h00);
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        step();
        chk("zero_done_end", done_o, 0);
        chk("zero_busy_end", busy_o, 0);

        do_start(8'h42);
        run_count(42, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
